bus_arbiter: RTL

//  Round-robin arbiter for the shared snoop bus; sits directly upstream of snoop_bus.

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/bus_arbiter_if.sv | 30 +++
 rtl/bus_arbiter_rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the snoop-bus arbiter: FSM state encoding, default
// requester count and the round-robin pointer increment.
package bus_arbiter_pkg;

  localparam int NUM_CPUS  = 4;
  localparam int ARB_IDX_W = $clog2(NUM_CPUS);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Wrap by explicit compare so non-power-of-2 requester counts work.
  function automatic int rr_next(input int idx, input int num);
    return (idx == num - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the CPU requesters and the snoop-bus arbiter.
// The arbiter takes the master modport; requesters and monitors take slave.
interface bus_arbiter_if #(
  parameter int NUM_CPUS = bus_arbiter_pkg::NUM_CPUS
);
  localparam int IDX_W = $clog2(NUM_CPUS);

  logic [NUM_CPUS-1:0] req;
  logic                bus_done;
  logic [NUM_CPUS-1:0] gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                timeout_err;

  modport master (
    input  req,
    input  bus_done,
    output gnt,
    output gnt_idx,
    output timeout_err
  );

  modport slave (
    output req,
    output bus_done,
    input  gnt,
    input  gnt_idx,
    input  timeout_err
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotates req so rr_ptr lands at bit 0,
// priority-encodes the lowest set bit, then maps the offset back to a CPU index.
module bus_arbiter_rr_pick #(
  parameter  int NUM_CPUS = bus_arbiter_pkg::NUM_CPUS,
  localparam int IDX_W    = $clog2(NUM_CPUS)
) (
  input  logic [NUM_CPUS-1:0] req,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [IDX_W-1:0]    winner,
  output logic                any
);

  localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_CPUS);

  logic [2*NUM_CPUS-1:0] dbl;
  logic [NUM_CPUS-1:0]   rot;
  logic [IDX_W-1:0]      offset;
  logic [IDX_W:0]        sum;

  // NOTE: every signal written here gets a default before any branch or loop,
  // otherwise a path that skips the assignment would infer a latch.
  always_comb begin
    dbl    = {req, req} >> rr_ptr;
    rot    = dbl[NUM_CPUS-1:0];
    offset = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      if (rot[i]) offset = IDX_W'(i);
    end
    sum    = {1'b0, rr_ptr} + {1'b0, offset};
    winner = (sum >= NUM_W) ? IDX_W'(sum - NUM_W) : sum[IDX_W-1:0];
    any    = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin snoop-bus arbiter: registered one-hot grant held until bus_done
// or the hold watchdog expires, with a dead cycle between consecutive grants.
module bus_arbiter #(
  parameter int NUM_CPUS = bus_arbiter_pkg::NUM_CPUS,
  parameter int MAX_HOLD = 64
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);
  import bus_arbiter_pkg::*;

  localparam int IDX_W  = $clog2(NUM_CPUS);
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NUM_CPUS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tmo_q, tmo_d;
  logic [IDX_W-1:0]    winner;
  logic                any;

  bus_arbiter_rr_pick #(.NUM_CPUS(NUM_CPUS)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          gnt_d   = {{(NUM_CPUS-1){1'b0}}, 1'b1} << winner;
          idx_d   = winner;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
        // Completion wins a tie with the watchdog, so no error in that case.
        if (bus.bus_done || hold_q == HOLD_LAST) begin
          gnt_d    = '0;
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(rr_next(int'(idx_q), NUM_CPUS));
          tmo_d    = !bus.bus_done;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_idx     = idx_q;
  assign bus.timeout_err = tmo_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q));

  a_gnt_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == GRANT) |=> (state_q == IDLE || $stable(gnt_q)));

  a_tmo_after_grant: assert property (@(posedge clk) disable iff (rst)
    tmo_q |-> $past(state_q) == GRANT);

endmodule
